sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's FIFO block and is used where producer and consumer share one clock. Over the previous FIFO it generalises data width and depth, and adds:
- selectable first-word-fall-through (FWFT) read mode,
- programmable almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags.
It sits between a streaming producer and consumer in the datapath. Occupancy is exposed through fifo_counter.

Parameters:
DATA_W, 8, width of wdata/rdata in bits
DEPTH, 16, number of entries; power of two, >= 4
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
(CNT_W = log2(DEPTH)+1, derived, not overridable)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write request
wdata  in  DATA_W  write data, sampled when a write is accepted
rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
rdata  out  DATA_W  read data
fifo_counter  out  CNT_W  current occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
overflow  out  1  sticky: a write was rejected
underflow  out  1  sticky: a read was rejected
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst=1 at clk edge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0, rdata=0 (standard mode).
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset. Reset overrides every other input in that cycle, including mid-burst.
- Acceptance:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc). Write-while-full is accepted only if a read is accepted in the same cycle.
  - Read-while-empty is rejected even if a write occurs in the same cycle.
- Pointers:
  - log2(DEPTH)-bit.
  - On wr_acc: mem[wr_ptr]<=wdata, wr_ptr+1.
  - On rd_acc: rd_ptr+1.
  - Both wrap naturally from DEPTH-1 to 0.
- Count:
  - +1 on wr_acc only; -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - Never exceeds DEPTH and never goes below 0.
- Flags: full, empty, almost_full and almost_empty decode from the registered count. They update in the cycle after the causing edge, with no combinational path from wr_en/rd_en.
- Standard mode (FWFT=0):
  - rdata <= mem[rd_ptr] on rd_acc, valid the cycle after the edge (1-cycle latency).
  - rdata holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - rdata = mem[rd_ptr] continuously; valid whenever empty=0.
  - rd_acc pops the word, and the next word appears after the edge.
  - The first write into an empty FIFO is visible (empty=0, rdata=word) one cycle after the write edge.
- Errors:
  - overflow<=1 when wr_en & !wr_acc.
  - underflow<=1 when rd_en & !rd_acc.
  - Both are sticky until err_clr or rst.
  - If err_clr coincides with a new error, the flag stays 1 (set wins).
  - Rejected operations do not alter pointers, count or memory.

Test Plan:
- Reset, then write 0x01..0x10 (16 words) with rd_en=0 -> fifo_counter steps 1..16. almost_full rises after the 14th write. full=1 after the 16th. empty=0 after the first.
- With the FIFO full, pulse wr_en with wdata=0xAA, rd_en=0 -> write ignored, count stays 16, overflow=1 and stays 1. err_clr pulse -> overflow=0.
- Full FIFO, wr_en=rd_en=1 with wdata=0x55 for 1 cycle -> count stays 16, no overflow. Standard mode: rdata=0x01 next cycle. 0x55 is read last after draining.
- Drain 16 reads (standard mode) -> rdata = 0x01..0x10 (or 0x02..0x10,0x55 after the previous test), each one cycle after its read. Then empty=1 and almost_empty=1. One more rd_en -> underflow=1, rdata holds the last value.
- Write and read continuously for 40 cycles with an offset of 3 -> pointers wrap at least twice, data order is preserved, count stays at 3, no error flags.
- FWFT=1 build: write 0x3C into an empty FIFO -> the next cycle shows empty=0 and rdata=0x3C with no rd_en. Pulse rd_en -> empty=1. Assert rst mid-burst at count=5 -> the next cycle shows count=0 and empty=1.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock FIFO with selectable standard/FWFT read mode,
//               programmable almost-full/almost-empty thresholds and sticky
//               overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   fifo_counter,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF    = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE    = c_CNT_W'(AE_LEVEL);
    localparam logic [c_CNT_W-1:0] c_CNT_1 = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = c_PTR_W'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_rd_acc;
    logic               w_wr_acc;

    // Status decodes from the registered count only, so no input reaches a flag
    assign w_full   = (r_count == c_FULL);
    assign w_empty  = (r_count == '0);

    // A write into a full FIFO is legal when a read frees a slot in the same cycle
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CNT_1;
                2'b01:   r_count <= r_count - c_CNT_1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky errors: a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_en & ~w_wr_acc) | (r_overflow  & ~err_clr);
            r_underflow <= (rd_en & ~w_rd_acc) | (r_underflow & ~err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_rd_acc) begin
                    r_rdata <= r_mem[r_rd_ptr];
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

    assign fifo_counter = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench driving a standard and an FWFT instance
//               with shared stimulus against a queue-based data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int c_DEPTH = 16;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] wd;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wdata = '0;

    logic [7:0] rdata_s, rdata_f;
    logic [4:0] cnt_s, cnt_f;
    logic       full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;

    int         n_tests = 0;
    int         n_fail  = 0;
    vec_t       vecs[$];
    logic [7:0] model[$];
    logic [7:0] last_rd = '0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(c_DEPTH), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_s), .fifo_counter(cnt_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .overflow(ovf_s),
        .underflow(unf_s), .err_clr(err_clr)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(c_DEPTH), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
        .rdata(rdata_f), .fifo_counter(cnt_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .overflow(ovf_f),
        .underflow(unf_f), .err_clr(err_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags follow directly from the occupancy and the thresholds 14 / 2
    task automatic add(input logic wr, input logic rd, input logic clr,
                       input logic [7:0] wd, input int cnt,
                       input logic ovf, input logic unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd; v.cnt = cnt;
        v.full = (cnt == 16); v.empty = (cnt == 0);
        v.af = (cnt >= 14); v.ae = (cnt <= 2);
        v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        logic       rda, wra;
        logic [7:0] exp_rd;
        rda    = v.rd && (model.size() != 0);
        wra    = v.wr && ((model.size() != c_DEPTH) || rda);
        exp_rd = last_rd;
        if (rda) exp_rd = model.pop_front();
        if (wra) model.push_back(v.wd);
        wr_en = v.wr; rd_en = v.rd; err_clr = v.clr; wdata = v.wd;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        chk("count_std",  int'(cnt_s),   v.cnt);
        chk("count_fwft", int'(cnt_f),   v.cnt);
        chk("full",       int'(full_s),  int'(v.full));
        chk("empty_std",  int'(empty_s), int'(v.empty));
        chk("empty_fwft", int'(empty_f), int'(v.empty));
        chk("almost_full",  int'(af_s),  int'(v.af));
        chk("almost_empty", int'(ae_s),  int'(v.ae));
        chk("overflow",   int'(ovf_s),   int'(v.ovf));
        chk("underflow",  int'(unf_s),   int'(v.unf));
        chk("overflow_fwft",  int'(ovf_f), int'(v.ovf));
        chk("underflow_fwft", int'(unf_f), int'(v.unf));
        chk("rdata_std",  int'(rdata_s), int'(exp_rd));
        last_rd = exp_rd;
        if (model.size() != 0) chk("rdata_fwft", int'(rdata_f), int'(model[0]));
    endtask

    task automatic do_reset(input logic wr);
        rst = 1'b1; wr_en = wr; wdata = 8'hEE;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0;
        model.delete();
        last_rd = '0;
        chk("rst_count_std",  int'(cnt_s), 0);
        chk("rst_count_fwft", int'(cnt_f), 0);
        chk("rst_empty_std",  int'(empty_s), 1);
        chk("rst_empty_fwft", int'(empty_f), 1);
        chk("rst_full",  int'(full_s), 0);
        chk("rst_ae",    int'(ae_s), 1);
        chk("rst_af",    int'(af_s), 0);
        chk("rst_ovf",   int'(ovf_s), 0);
        chk("rst_unf",   int'(unf_s), 0);
        chk("rst_rdata", int'(rdata_s), 0);
    endtask

    initial begin
        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) add(1, 0, 0, 8'(i), i, 0, 0);
        // Rejected write while full, sticky, then cleared
        add(1, 0, 0, 8'hAA, 16, 1, 0);
        add(0, 0, 0, 8'h00, 16, 1, 0);
        add(0, 0, 1, 8'h00, 16, 0, 0);
        // Simultaneous write/read while full
        add(1, 1, 0, 8'h55, 16, 0, 0);
        // Drain all 16 (0x02..0x10, 0x55)
        for (int i = 1; i <= 16; i++) add(0, 1, 0, 8'h00, 16 - i, 0, 0);
        // Read while empty: underflow, rdata holds
        add(0, 1, 0, 8'h00, 0, 0, 1);
        add(0, 0, 1, 8'h00, 0, 0, 0);
        // Read rejected on empty even with a write in the same cycle
        add(1, 1, 0, 8'h77, 1, 0, 1);
        add(0, 0, 1, 8'h00, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 0);
        // Clear coinciding with a new underflow keeps the flag set
        add(0, 1, 1, 8'h00, 0, 0, 1);
        add(0, 0, 1, 8'h00, 0, 0, 0);
        // Streaming with an offset of 3 across multiple pointer wraps
        for (int i = 1; i <= 3; i++) add(1, 0, 0, 8'(8'h80 + i), i, 0, 0);
        for (int i = 0; i < 40; i++) add(1, 1, 0, 8'(8'hC0 + i), 3, 0, 0);
        for (int i = 2; i >= 0; i--) add(0, 1, 0, 8'h00, i, 0, 0);
        // Build up five entries ahead of the mid-burst reset
        for (int i = 1; i <= 5; i++) add(1, 0, 0, 8'(8'h10 + i), i, 0, 0);

        do_reset(1'b0);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset mid-burst with a write pending: the write must be lost
        chk("pre_rst_count", int'(cnt_s), 5);
        do_reset(1'b1);

        // FWFT: first word shows without a read, then pops away
        vecs.delete();
        add(1, 0, 0, 8'h3C, 1, 0, 0);
        add(0, 0, 0, 8'h00, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
        chk("fwft_first_word", int'(last_rd), 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
